// File: rtl/bru_pkg.sv
// Shared encodings and constants for the branch resolve unit and its update FIFO.
package bru_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLEZ = 3'b010,
    BR_BGTZ = 3'b011,
    BR_BLTZ = 3'b100,
    BR_BGEZ = 3'b101
  } branch_op_e;

  localparam int PC_INCR = 4;
  localparam int STATS_W = 32;

endpackage

// File: rtl/bru_update_fifo.sv
// Circular-buffer FIFO holding resolved branches until the BTB drains them.
// Head is read straight from storage, so a new entry is never visible in its push cycle.
module bru_update_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered MIPS branch resolution with mispredict/redirect and a BTB update queue.
// Define BRU_STATS_EN to add saturating BranchCount/MispredCount outputs.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] ReadA,
  input  logic [DATA_W-1:0] ReadB,
  input  logic [2:0]        BranchOp,
  input  logic [ADDR_W-1:0] BranchPC,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              PredTaken,
  input  logic [ADDR_W-1:0] PredTarget,
  output logic              ResValid,
  output logic              BranchResult,
  output logic              Mispredict,
  output logic [ADDR_W-1:0] RedirectPC,
  output logic              UpdValid,
  input  logic              UpdReady,
  output logic [ADDR_W-1:0] UpdPC,
  output logic [ADDR_W-1:0] UpdTarget,
`ifdef BRU_STATS_EN
  output logic [STATS_W-1:0] BranchCount,
  output logic [STATS_W-1:0] MispredCount,
`endif
  output logic              UpdTaken
);

  localparam int UPD_W = 2 * ADDR_W + 1;

  logic              accept;
  logic              taken;
  logic              mispred_next;
  logic [ADDR_W-1:0] redirect_next;
  logic              a_neg;
  logic              a_zero;
  logic              fifo_full;
  logic              fifo_empty;
  logic [UPD_W-1:0]  fifo_head;

  assign accept  = InValid & InReady;
  assign InReady = ~fifo_full;
  assign a_neg   = ReadA[DATA_W-1];
  assign a_zero  = (ReadA == '0);

  always_comb begin
    taken = 1'b0;
    case (BranchOp)
      BR_BEQ:  taken = (ReadA == ReadB);
      BR_BNE:  taken = (ReadA != ReadB);
      BR_BLEZ: taken = a_neg | a_zero;
      BR_BGTZ: taken = ~a_neg & ~a_zero;
      BR_BLTZ: taken = a_neg;
      BR_BGEZ: taken = ~a_neg;
      default: taken = 1'b0;
    endcase
  end

  assign mispred_next  = (taken != PredTaken) |
                         (taken & PredTaken & (PredTarget != BranchTarget));
  assign redirect_next = taken ? BranchTarget : BranchPC + ADDR_W'(PC_INCR);

  // Result fields only update on accept so they hold between resolutions.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ResValid     <= 1'b0;
      BranchResult <= 1'b0;
      Mispredict   <= 1'b0;
      RedirectPC   <= '0;
    end else begin
      ResValid <= accept;
      if (accept) begin
        BranchResult <= taken;
        Mispredict   <= mispred_next;
        RedirectPC   <= redirect_next;
      end
    end
  end

  bru_update_fifo #(
    .WIDTH (UPD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_update_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (accept),
    .push_data ({BranchPC, BranchTarget, taken}),
    .pop       (UpdReady),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign UpdValid  = ~fifo_empty;
  assign UpdPC     = fifo_head[UPD_W-1 -: ADDR_W];
  assign UpdTarget = fifo_head[ADDR_W:1];
  assign UpdTaken  = fifo_head[0];

`ifdef BRU_STATS_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      BranchCount  <= '0;
      MispredCount <= '0;
    end else begin
      if (accept && (BranchCount != '1)) begin
        BranchCount <= BranchCount + STATS_W'(1);
      end
      if (ResValid && Mispredict && (MispredCount != '1)) begin
        MispredCount <= MispredCount + STATS_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: stimulus queues expectations, a negedge monitor checks them.
module tb_branch_resolve_unit;
  import bru_pkg::*;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int FIFO_DEPTH = 4;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              InValid;
  logic              InReady;
  logic [DATA_W-1:0] ReadA;
  logic [DATA_W-1:0] ReadB;
  logic [2:0]        BranchOp;
  logic [ADDR_W-1:0] BranchPC;
  logic [ADDR_W-1:0] BranchTarget;
  logic              PredTaken;
  logic [ADDR_W-1:0] PredTarget;
  logic              ResValid;
  logic              BranchResult;
  logic              Mispredict;
  logic [ADDR_W-1:0] RedirectPC;
  logic              UpdValid;
  logic              UpdReady;
  logic [ADDR_W-1:0] UpdPC;
  logic [ADDR_W-1:0] UpdTarget;
  logic              UpdTaken;
`ifdef BRU_STATS_EN
  logic [31:0]       BranchCount;
  logic [31:0]       MispredCount;
`endif

  typedef struct {
    logic        taken;
    logic        mis;
    logic [31:0] redir;
  } res_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
  } upd_t;

  res_t res_q[$];
  upd_t upd_q[$];
  res_t res_exp;
  upd_t upd_exp;
  int   checks = 0;
  int   errors = 0;

  branch_resolve_unit #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .InValid      (InValid),
    .InReady      (InReady),
    .ReadA        (ReadA),
    .ReadB        (ReadB),
    .BranchOp     (BranchOp),
    .BranchPC     (BranchPC),
    .BranchTarget (BranchTarget),
    .PredTaken    (PredTaken),
    .PredTarget   (PredTarget),
    .ResValid     (ResValid),
    .BranchResult (BranchResult),
    .Mispredict   (Mispredict),
    .RedirectPC   (RedirectPC),
    .UpdValid     (UpdValid),
    .UpdReady     (UpdReady),
    .UpdPC        (UpdPC),
    .UpdTarget    (UpdTarget),
`ifdef BRU_STATS_EN
    .BranchCount  (BranchCount),
    .MispredCount (MispredCount),
`endif
    .UpdTaken     (UpdTaken)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a result or completes an update handshake.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (ResValid) begin
        if (res_q.size() == 0) begin
          checkOutput("res_unexpected", 32'd1, 32'd0);
        end else begin
          res_exp = res_q.pop_front();
          checkOutput("branch_result", {31'd0, BranchResult}, {31'd0, res_exp.taken});
          checkOutput("mispredict", {31'd0, Mispredict}, {31'd0, res_exp.mis});
          checkOutput("redirect_pc", RedirectPC, res_exp.redir);
        end
      end
      if (UpdValid && UpdReady) begin
        if (upd_q.size() == 0) begin
          checkOutput("upd_unexpected", 32'd1, 32'd0);
        end else begin
          upd_exp = upd_q.pop_front();
          checkOutput("upd_pc", UpdPC, upd_exp.pc);
          checkOutput("upd_target", UpdTarget, upd_exp.tgt);
          checkOutput("upd_taken", {31'd0, UpdTaken}, {31'd0, upd_exp.taken});
        end
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc, input logic [31:0] tgt, input logic pt,
                               input logic [31:0] ptgt, input logic exp_taken, input logic exp_mis,
                               input logic [31:0] exp_redir, input logic exp_accept);
    res_t r;
    upd_t u;
    BranchOp     = op;
    ReadA        = a;
    ReadB        = b;
    BranchPC     = pc;
    BranchTarget = tgt;
    PredTaken    = pt;
    PredTarget   = ptgt;
    InValid      = 1'b1;
    @(negedge Clk);
    checkOutput("in_ready", {31'd0, InReady}, {31'd0, exp_accept});
    if (InReady) begin
      r.taken = exp_taken;
      r.mis   = exp_mis;
      r.redir = exp_redir;
      res_q.push_back(r);
      u.pc    = pc;
      u.tgt   = tgt;
      u.taken = exp_taken;
      upd_q.push_back(u);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    InValid = 1'b0;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    Reset        = 1'b1;
    InValid      = 1'b0;
    ReadA        = '0;
    ReadB        = '0;
    BranchOp     = '0;
    BranchPC     = '0;
    BranchTarget = '0;
    PredTaken    = 1'b0;
    PredTarget   = '0;
    UpdReady     = 1'b1;
    #3;
    checkOutput("rst_res_valid", {31'd0, ResValid}, 32'd0);
    checkOutput("rst_branch_result", {31'd0, BranchResult}, 32'd0);
    checkOutput("rst_mispredict", {31'd0, Mispredict}, 32'd0);
    checkOutput("rst_redirect_pc", RedirectPC, 32'd0);
    checkOutput("rst_upd_valid", {31'd0, UpdValid}, 32'd0);
    checkOutput("rst_upd_pc", UpdPC, 32'd0);
    checkOutput("rst_upd_target", UpdTarget, 32'd0);
    checkOutput("rst_upd_taken", {31'd0, UpdTaken}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, InReady}, 32'd1);
    #9;
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Condition and redirect vectors with the update queue draining freely.
    applyStimulus(BR_BEQ,  32'h1234, 32'h1234, 32'h200, 32'h400, 1'b1, 32'h400, 1'b1, 1'b0, 32'h400, 1'b1);
    applyStimulus(BR_BLTZ, 32'h80000000, 32'h0, 32'h100, 32'h300, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 1'b1);
    applyStimulus(BR_BGEZ, 32'h80000000, 32'h0, 32'h100, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'h104, 1'b1);
    applyStimulus(BR_BNE,  32'h1, 32'h2, 32'h180, 32'h600, 1'b1, 32'h500, 1'b1, 1'b1, 32'h600, 1'b1);
    applyStimulus(BR_BNE,  32'h5, 32'h5, 32'hFFFFFFFC, 32'h700, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(BR_BLEZ, 32'h0, 32'h9, 32'h40, 32'h800, 1'b1, 32'h800, 1'b1, 1'b0, 32'h800, 1'b1);
    applyStimulus(BR_BGTZ, 32'h0, 32'h9, 32'h50, 32'h880, 1'b1, 32'h880, 1'b0, 1'b1, 32'h54, 1'b1);
    applyStimulus(3'b110,  32'h0, 32'h0, 32'h60, 32'h8C0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h64, 1'b1);
    applyStimulus(BR_BGTZ, 32'h7FFFFFFF, 32'h0, 32'h70, 32'h900, 1'b0, 32'h0, 1'b1, 1'b1, 32'h900, 1'b1);
    idle(3);

    // Fill with the BTB stalled, then drain.
    UpdReady = 1'b0;
    applyStimulus(BR_BEQ,  32'h7, 32'h7, 32'h1000, 32'h2000, 1'b1, 32'h2000, 1'b1, 1'b0, 32'h2000, 1'b1);
    applyStimulus(BR_BEQ,  32'h7, 32'h8, 32'h1010, 32'h2010, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1014, 1'b1);
    applyStimulus(BR_BLTZ, 32'hFFFFFFFF, 32'h0, 32'h1020, 32'h2020, 1'b1, 32'h2020, 1'b1, 1'b0, 32'h2020, 1'b1);
    applyStimulus(BR_BGEZ, 32'hFFFFFFFF, 32'h0, 32'h1030, 32'h2030, 1'b1, 32'h2030, 1'b0, 1'b1, 32'h1034, 1'b1);
    applyStimulus(BR_BEQ,  32'h1, 32'h1, 32'h1040, 32'h2040, 1'b1, 32'h2040, 1'b1, 1'b0, 32'h2040, 1'b0);
    InValid = 1'b0;
    checkOutput("full_in_ready", {31'd0, InReady}, 32'd0);
    checkOutput("full_upd_valid", {31'd0, UpdValid}, 32'd1);
    UpdReady = 1'b1;
    @(posedge Clk);
    #1;
    checkOutput("in_ready_after_pop", {31'd0, InReady}, 32'd1);
    idle(6);
    checkOutput("drain_upd_valid", {31'd0, UpdValid}, 32'd0);
    checkOutput("drain_queue_left", upd_q.size(), 32'd0);

    // Hold two entries, then push and pop together for ten cycles.
    UpdReady = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) UpdReady = 1'b1;
      pc  = 32'h3000 + 32'(i * 16);
      tgt = 32'h4000 + 32'(i * 16);
      tk  = ((i % 2) == 0);
      applyStimulus(BR_BEQ, 32'(i), 32'(i & ~1), pc, tgt, 1'b1, tgt, tk, ~tk, tk ? tgt : pc + 32'd4, 1'b1);
      if (i >= 2) checkOutput("steady_upd_valid", {31'd0, UpdValid}, 32'd1);
    end
    idle(5);
    checkOutput("steady_queue_left", upd_q.size(), 32'd0);

    // Asynchronous reset with a result and queued updates in flight.
    UpdReady = 1'b0;
    applyStimulus(BR_BEQ, 32'h2, 32'h2, 32'h5000, 32'h6000, 1'b0, 32'h0, 1'b1, 1'b1, 32'h6000, 1'b1);
    applyStimulus(BR_BNE, 32'h2, 32'h2, 32'h5010, 32'h6010, 1'b1, 32'h6010, 1'b0, 1'b1, 32'h5014, 1'b1);
    InValid = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("mid_rst_res_valid", {31'd0, ResValid}, 32'd0);
    checkOutput("mid_rst_upd_valid", {31'd0, UpdValid}, 32'd0);
    checkOutput("mid_rst_redirect_pc", RedirectPC, 32'd0);
    checkOutput("mid_rst_in_ready", {31'd0, InReady}, 32'd1);
`ifdef BRU_STATS_EN
    checkOutput("mid_rst_branch_count", BranchCount, 32'd0);
    checkOutput("mid_rst_mispred_count", MispredCount, 32'd0);
`endif
    res_q.delete();
    upd_q.delete();
    #3;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    UpdReady = 1'b1;
    applyStimulus(BR_BLEZ, 32'h80000001, 32'h0, 32'h7000, 32'h7100, 1'b0, 32'h0, 1'b1, 1'b1, 32'h7100, 1'b1);
    idle(4);
`ifdef BRU_STATS_EN
    checkOutput("post_rst_branch_count", BranchCount, 32'd1);
    checkOutput("post_rst_mispred_count", MispredCount, 32'd1);
`endif
    checkOutput("final_res_left", res_q.size(), 32'd0);
    checkOutput("final_upd_left", upd_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Registered, parametrised branch resolution stage for the MIPS BTB pipeline. Evaluates six MIPS branch conditions on register operands, compares the outcome against the BTB prediction carried down the pipe, and raises a one-cycle mispredict/redirect. It also queues every resolved branch into a small update FIFO that the BTB drains through a valid/ready handshake.

## Interface
- DATA_W, 32, operand width
- ADDR_W, 32, PC/target width
- FIFO_DEPTH, 4, BTB update FIFO entries (power of two, ≥2)

- Clk  input  1  clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- InValid  input  1  branch presented this cycle
- InReady  output  1  unit can accept; = update FIFO not full
- ReadA  input  DATA_W  rs operand
- ReadB  input  DATA_W  rt operand
- BranchOp  input  3  000 BEQ, 001 BNE, 010 BLEZ, 011 BGTZ, 100 BLTZ, 101 BGEZ, 110/111 never-taken
- BranchPC  input  ADDR_W  PC of the branch
- BranchTarget  input  ADDR_W  computed taken target
- PredTaken  input  1  BTB predicted taken
- PredTarget  input  ADDR_W  BTB predicted target
- ResValid  output  1  resolution valid (one cycle per accepted branch)
- BranchResult  output  1  actual taken
- Mispredict  output  1  redirect required; qualified by ResValid
- RedirectPC  output  ADDR_W  correct next PC
- UpdValid  output  1  FIFO head valid
- UpdReady  input  1  BTB accepts head
- UpdPC, UpdTarget  output  ADDR_W  head branch PC / target
- UpdTaken  output  1  head actual outcome

## Operation
- Accept = InValid & InReady.
- Conditions: BEQ A==B; BNE A!=B; BLEZ/BGTZ/BLTZ/BGEZ compare ReadA as signed DATA_W against zero; ReadB ignored for those. Codes 110/111: taken=0.
- Mispredict = (taken != PredTaken) | (taken & PredTaken & PredTarget != BranchTarget).
- RedirectPC = taken ? BranchTarget : BranchPC + 4, modulo 2^ADDR_W (wraps at all-ones).
- Every accepted branch pushes {BranchPC, BranchTarget, taken} into the FIFO, regardless of mispredict.
- FIFO pops when UpdValid & UpdReady. Circular read/write pointers with a separate count; pointers wrap at FIFO_DEPTH.

## Timing
- Reset values: ResValid 0, BranchResult 0, Mispredict 0, RedirectPC 0, UpdValid 0, UpdPC/UpdTarget 0, UpdTaken 0, InReady 1, FIFO empty.
- Latency: ResValid/BranchResult/Mispredict/RedirectPC are registered, 1 cycle after accept. They are held for exactly one cycle; ResValid=0 otherwise, and the other outputs hold their last value.
- FIFO: an entry pushed at edge N is visible on UpdValid after edge N (UpdValid high in cycle N+1). No same-cycle fall-through.
- Full: InReady=0 and InValid is ignored. A pop while full does not enable a same-cycle push; InReady rises the cycle after.
- Empty: UpdValid=0 and UpdReady is ignored.
- Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
- Reset asserted mid-operation: all state clears immediately and asynchronously. In-flight results and queued updates are discarded.

## Configuration
- BRU_STATS_EN defined: adds outputs BranchCount and MispredCount (32 bits each).
  - BranchCount increments on every accept.
  - MispredCount increments on every ResValid & Mispredict.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- BRU_STATS_EN undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Package bru_pkg holds:
  - BranchOp encodings (BR_BEQ … BR_BGEZ)
  - PC_INCR = 4
  - stats counter width = 32
- One sub-module, bru_update_fifo: parametrised by width and FIFO_DEPTH; push/pop/full/empty; async active-high reset.

## Test plan
- BEQ, A=B=0x1234, PredTaken=1, PredTarget=BranchTarget=0x400 → next cycle ResValid=1, BranchResult=1, Mispredict=0, RedirectPC=0x400.
- BLTZ, A=0x80000000, PredTaken=0, BranchPC=0x100 → BranchResult=1, Mispredict=1, RedirectPC=BranchTarget. Repeat with BGEZ on the same A → BranchResult=0, RedirectPC=0x104.
- BNE taken, PredTaken=1, PredTarget=0x500, BranchTarget=0x600 → Mispredict=1. BranchPC=0xFFFFFFFC not taken → RedirectPC=0x0.
- UpdReady=0 with 4 back-to-back accepts → InReady drops after the 4th; a 5th InValid is ignored. Raise UpdReady → entries drain in order with correct PC/target/taken, and InReady returns 1 the cycle after the first pop.
- Concurrent push and pop at count 2 for 10 cycles → count stays 2, ordering preserved. Reset asserted mid-stream → UpdValid and ResValid go 0 immediately, and stats counters read 0 (BRU_STATS_EN build).
